cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data/instruction cache controller.
- Sits directly downstream of the CPU request stub and upstream of main memory.
- Accepts word-addressed requests (Req_CPU/Wr_CPU/A_CPU/Ins_Type) and answers each with a one-cycle Ready_Cache pulse.
- Forwards misses, writes and uncached accesses to memory over a request/ready handshake.

---
 rtl/cache_ctrl_if.sv | 27 ++
 rtl/cache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle for cache_ctrl.
// slave = the cache controller's view; master = the CPU stub plus main memory driving it.
interface cache_ctrl_if;
    logic        Req_CPU;
    logic        Wr_CPU;
    logic [31:0] A_CPU;
    logic [31:0] Wdata_CPU;
    logic [1:0]  Ins_Type;
    logic        Ready_Cache;
    logic [31:0] Rdata_Cache;
    logic        Req_Mem;
    logic        Wr_Mem;
    logic [31:0] A_Mem;
    logic [31:0] Wdata_Mem;
    logic [31:0] Rdata_Mem;
    logic        Ready_Mem;

    modport slave (
        input  Req_CPU, Wr_CPU, A_CPU, Wdata_CPU, Ins_Type, Rdata_Mem, Ready_Mem,
        output Ready_Cache, Rdata_Cache, Req_Mem, Wr_Mem, A_Mem, Wdata_Mem
    );

    modport master (
        output Req_CPU, Wr_CPU, A_CPU, Wdata_CPU, Ins_Type, Rdata_Mem, Ready_Mem,
        input  Ready_Cache, Rdata_Cache, Req_Mem, Wr_Mem, A_Mem, Wdata_Mem
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one-word lines.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
`ifdef CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    cache_ctrl_if.slave bus
);
    localparam int NUM_LINES = 2 ** INDEX_BITS;
    localparam int TAG_BITS  = 32 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_READ, MEM_WRITE, RESPOND} state_e;
    typedef enum logic [1:0] {T_DATA = 2'b00, T_IFETCH = 2'b01, T_UNCACHED = 2'b10, T_INVAL = 2'b11} ins_type_e;

    state_e          state_q, state_d;
    ins_type_e       type_q, type_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            req_mem_q, req_mem_d;
    logic            wr_mem_q, wr_mem_d;
    logic [31:0]     a_mem_q, a_mem_d;
    logic [31:0]     wdata_mem_q, wdata_mem_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    logic [INDEX_BITS-1:0] idx;
    logic                  hit;
    logic                  line_we, valid_set, valid_clr;
    logic [31:0]           line_wdata;

    assign idx = addr_q[INDEX_BITS-1:0];
    assign hit = valid_q[idx] && (tag_q[idx] == addr_q[31:INDEX_BITS]);

`ifdef CACHE_STATS_EN
    logic        hit_inc, miss_inc;
    logic [31:0] hit_cnt_q, miss_cnt_q;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        a_mem_d     = a_mem_q;
        wdata_mem_d = wdata_mem_q;
        line_we     = 1'b0;
        valid_set   = 1'b0;
        valid_clr   = 1'b0;
        line_wdata  = wdata_q;
`ifdef CACHE_STATS_EN
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.Req_CPU) begin
                    addr_d  = bus.A_CPU;
                    wdata_d = bus.Wdata_CPU;
                    type_d  = ins_type_e'(bus.Ins_Type);
                    // An instruction fetch is always a read, whatever Wr_CPU says.
                    wr_d    = bus.Wr_CPU && (bus.Ins_Type != T_IFETCH);
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
`ifdef CACHE_STATS_EN
                if (type_q == T_DATA || type_q == T_IFETCH) begin
                    hit_inc  = hit;
                    miss_inc = !hit;
                end
`endif
                if (type_q == T_INVAL) begin
                    valid_clr = 1'b1;
                    state_d   = RESPOND;
                end else if (!wr_q) begin
                    if (hit && type_q != T_UNCACHED) begin
                        rdata_d = data_q[idx];
                        state_d = RESPOND;
                    end else begin
                        a_mem_d = addr_q;
                        state_d = MEM_READ;
                    end
                end else begin
                    line_we     = hit && (type_q == T_DATA);
                    a_mem_d     = addr_q;
                    wdata_mem_d = wdata_q;
                    state_d     = MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (bus.Ready_Mem) begin
                    rdata_d = bus.Rdata_Mem;
                    if (type_q != T_UNCACHED) begin
                        line_we    = 1'b1;
                        valid_set  = 1'b1;
                        line_wdata = bus.Rdata_Mem;
                    end
                    state_d = RESPOND;
                end
            end
            MEM_WRITE: begin
                if (bus.Ready_Mem) state_d = RESPOND;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they leave flops aligned with the state.
        ready_d   = (state_d == RESPOND);
        req_mem_d = (state_d == MEM_READ) || (state_d == MEM_WRITE);
        wr_mem_d  = (state_d == MEM_WRITE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            type_q      <= T_DATA;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            req_mem_q   <= 1'b0;
            wr_mem_q    <= 1'b0;
            a_mem_q     <= '0;
            wdata_mem_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            req_mem_q   <= req_mem_d;
            wr_mem_q    <= wr_mem_d;
            a_mem_q     <= a_mem_d;
            wdata_mem_q <= wdata_mem_d;
            if (valid_set)      valid_q[idx] <= 1'b1;
            else if (valid_clr) valid_q[idx] <= 1'b0;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_wdata;
            tag_q[idx]  <= addr_q[31:INDEX_BITS];
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign bus.Ready_Cache = ready_q;
    assign bus.Rdata_Cache = rdata_q;
    assign bus.Req_Mem     = req_mem_q;
    assign bus.Wr_Mem      = wr_mem_q;
    assign bus.A_Mem       = a_mem_q;
    assign bus.Wdata_Mem   = wdata_mem_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus random traffic against a
// line-occupancy reference model; memory answers addr + 0x1000 three cycles after Req_Mem.
module tb_cache_ctrl;
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  typ;
        logic [31:0] wdata;
    } op_t;

    typedef struct packed {
        logic        timeout;
        logic [7:0]  latency;
        logic        mem_used;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] rdata;
        logic        ready_after;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_if bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    cache_ctrl #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .hit_count(hit_count), .miss_count(miss_count), .bus(bus)
    );
`else
    cache_ctrl #(.INDEX_BITS(6)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int checks = 0;
    int passes = 0;

    // Reference model: which full address occupies each line, and its data.
    bit          m_valid [64];
    logic [31:0] m_line  [64];
    logic [31:0] m_data  [64];
    logic [31:0] m_rdata;
    logic [31:0] m_hits, m_misses;

    // Observations made by the memory responder during one access.
    bit          mem_seen;
    logic        mem_wr_seen;
    logic [31:0] mem_addr_seen, mem_wdata_seen;

    function automatic void model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_rdata  = '0;
        m_hits   = '0;
        m_misses = '0;
    endfunction

    function automatic result_t model_access(op_t op);
        result_t e = '0;
        int  idx       = int'(op.addr % 64);
        bit  hit       = m_valid[idx] && (m_line[idx] == op.addr);
        bit  eff_wr    = op.wr && (op.typ != 2'b01);
        bit  cacheable = (op.typ == 2'b00) || (op.typ == 2'b01);
        if (cacheable) begin
            if (hit && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
            if (!hit && m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
        end
        e.latency = 8'd2;
        if (op.typ == 2'b11) begin
            m_valid[idx] = 1'b0;
        end else if (!eff_wr && hit && cacheable) begin
            m_rdata = m_data[idx];
        end else if (!eff_wr) begin
            e.latency  = 8'd5;
            e.mem_used = 1'b1;
            e.mem_addr = op.addr;
            m_rdata    = op.addr + 32'h1000;
            if (cacheable) begin
                m_valid[idx] = 1'b1;
                m_line[idx]  = op.addr;
                m_data[idx]  = m_rdata;
            end
        end else begin
            e.latency   = 8'd5;
            e.mem_used  = 1'b1;
            e.mem_wr    = 1'b1;
            e.mem_addr  = op.addr;
            e.mem_wdata = op.wdata;
            if (op.typ == 2'b00 && hit) m_data[idx] = op.wdata;
        end
        e.rdata = m_rdata;
        return e;
    endfunction

    function automatic op_t mk(logic [31:0] a, logic w, logic [1:0] t, logic [31:0] d);
        op_t o;
        o.addr = a; o.wr = w; o.typ = t; o.wdata = d;
        return o;
    endfunction

    function automatic string fmt(result_t r);
        return $sformatf("rdata=%h lat=%0d mem=%b wr=%b a=%h wd=%h rdy_next=%b timeout=%b",
                         r.rdata, r.latency, r.mem_used, r.mem_wr, r.mem_addr, r.mem_wdata,
                         r.ready_after, r.timeout);
    endfunction

    // Memory: Ready_Mem pulses on the third cycle Req_Mem has been seen high.
    initial begin : memory
        int cnt = 0;
        bus.Ready_Mem = 1'b0;
        bus.Rdata_Mem = '0;
        forever begin
            @(negedge clk);
            if (bus.Ready_Mem || !rst || !bus.Req_Mem) begin
                bus.Ready_Mem = 1'b0;
                cnt = 0;
            end else begin
                mem_seen = 1'b1;
                cnt++;
                if (cnt == 3) begin
                    bus.Ready_Mem  = 1'b1;
                    bus.Rdata_Mem  = bus.Wr_Mem ? 32'h0 : bus.A_Mem + 32'h1000;
                    mem_wr_seen    = bus.Wr_Mem;
                    mem_addr_seen  = bus.A_Mem;
                    mem_wdata_seen = bus.Wr_Mem ? bus.Wdata_Mem : 32'h0;
                    cnt = 0;
                end
            end
        end
    end

    task automatic access(input op_t op, input bit drop_early, output result_t r);
        r = '0;
        @(negedge clk);
        mem_seen = 1'b0; mem_wr_seen = 1'b0; mem_addr_seen = '0; mem_wdata_seen = '0;
        bus.Req_CPU   = 1'b1;
        bus.Wr_CPU    = op.wr;
        bus.A_CPU     = op.addr;
        bus.Wdata_CPU = op.wdata;
        bus.Ins_Type  = op.typ;
        r.timeout = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (drop_early && n == 1) bus.Req_CPU = 1'b0;
            if (bus.Ready_Cache === 1'b1) begin
                r.timeout = 1'b0;
                r.latency = 8'(n);
                r.rdata   = bus.Rdata_Cache;
                break;
            end
        end
        bus.Req_CPU = 1'b0;
        r.mem_used  = mem_seen;
        r.mem_wr    = mem_wr_seen;
        r.mem_addr  = mem_addr_seen;
        r.mem_wdata = mem_wdata_seen;
        @(negedge clk);
        r.ready_after = bus.Ready_Cache;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] got [6];
        string       nm  [6] = '{"Ready_Cache", "Req_Mem", "Wr_Mem", "Rdata_Cache", "A_Mem", "Wdata_Mem"};
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got = '{32'(bus.Ready_Cache), 32'(bus.Req_Mem), 32'(bus.Wr_Mem),
                bus.Rdata_Cache, bus.A_Mem, bus.Wdata_Mem};
        foreach (got[i]) begin
            checks++;
            if (got[i] !== 32'h0) $display("FAIL reset_%s got %h expected 0", nm[i], got[i]);
            else passes++;
        end
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.Ready_Cache, bus.Req_Mem} !== 2'b00)
            $display("FAIL reset_idle got ready/req=%b%b expected 00", bus.Ready_Cache, bus.Req_Mem);
        else passes++;
    endtask

    task automatic test_read_miss_hit();
        op_t ops[$];
        result_t e, o;
        ops.push_back(mk(32'h5, 1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h5, 1'b0, 2'b00, 32'h0));
        foreach (ops[i]) begin
            e = model_access(ops[i]);
            access(ops[i], 1'b0, o);
            checks++;
            if (o !== e) $display("FAIL read_miss_hit[%0d] got %s expected %s", i, fmt(o), fmt(e));
            else passes++;
        end
    endtask

    task automatic test_write_through();
        op_t ops[$];
        result_t e, o;
        ops.push_back(mk(32'h5, 1'b1, 2'b00, 32'hABCD));
        ops.push_back(mk(32'h5, 1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h7, 1'b1, 2'b00, 32'h7777));
        ops.push_back(mk(32'h7, 1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h5, 1'b1, 2'b10, 32'h1111));
        ops.push_back(mk(32'h5, 1'b0, 2'b00, 32'h0));
        foreach (ops[i]) begin
            e = model_access(ops[i]);
            access(ops[i], 1'b0, o);
            checks++;
            if (o !== e) $display("FAIL write_through[%0d] got %s expected %s", i, fmt(o), fmt(e));
            else passes++;
        end
    endtask

    task automatic test_aliasing();
        op_t ops[$];
        result_t e, o;
        ops.push_back(mk(32'h5,  1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h45, 1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h5,  1'b0, 2'b00, 32'h0));
        foreach (ops[i]) begin
            e = model_access(ops[i]);
            access(ops[i], 1'b0, o);
            checks++;
            if (o !== e) $display("FAIL aliasing[%0d] got %s expected %s", i, fmt(o), fmt(e));
            else passes++;
        end
    endtask

    task automatic test_ins_types();
        op_t ops[$];
        result_t e, o;
        ops.push_back(mk(32'h5, 1'b1, 2'b11, 32'h0));
        ops.push_back(mk(32'h5, 1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h5, 1'b1, 2'b00, 32'h2222));
        ops.push_back(mk(32'h5, 1'b0, 2'b10, 32'h0));
        ops.push_back(mk(32'h5, 1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h5, 1'b1, 2'b01, 32'h9999));
        ops.push_back(mk(32'h3A, 1'b1, 2'b01, 32'h9999));
        foreach (ops[i]) begin
            e = model_access(ops[i]);
            access(ops[i], 1'b0, o);
            checks++;
            if (o !== e) $display("FAIL ins_types[%0d] got %s expected %s", i, fmt(o), fmt(e));
            else passes++;
        end
    endtask

    task automatic test_early_release();
        op_t op;
        result_t e, o;
        op = mk(32'h123, 1'b0, 2'b00, 32'h0);
        e = model_access(op);
        access(op, 1'b1, o);
        checks++;
        if (o !== e) $display("FAIL early_release got %s expected %s", fmt(o), fmt(e));
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        op_t op;
        result_t e, o;
        bit found = 1'b0;
        op = mk(32'h200, 1'b0, 2'b00, 32'h0);
        e = model_access(op);
        access(op, 1'b0, o);
        checks++;
        if (o !== e) $display("FAIL mid_reset_fill got %s expected %s", fmt(o), fmt(e));
        else passes++;
        @(negedge clk);
        bus.Req_CPU = 1'b1; bus.Wr_CPU = 1'b0; bus.A_CPU = 32'h200; bus.Ins_Type = 2'b10;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            found = (bus.Req_Mem === 1'b1);
        end
        checks++;
        if (!found) $display("FAIL mid_reset_req got Req_Mem=%b expected 1 within 10 cycles", bus.Req_Mem);
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.Req_Mem, bus.Wr_Mem, bus.Ready_Cache} !== 3'b000)
            $display("FAIL mid_reset_abort got req/wr/ready=%b%b%b expected 000",
                     bus.Req_Mem, bus.Wr_Mem, bus.Ready_Cache);
        else passes++;
        bus.Req_CPU = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        op = mk(32'h200, 1'b0, 2'b00, 32'h0);
        e = model_access(op);
        access(op, 1'b0, o);
        checks++;
        if (o !== e) $display("FAIL mid_reset_reread got %s expected %s", fmt(o), fmt(e));
        else passes++;
    endtask

    task automatic test_stats();
        op_t ops[$];
        result_t e, o;
        apply_reset();
        ops.push_back(mk(32'h9,  1'b0, 2'b00, 32'h0));
        ops.push_back(mk(32'h9,  1'b0, 2'b01, 32'h0));
        ops.push_back(mk(32'h9,  1'b1, 2'b00, 32'h55));
        ops.push_back(mk(32'h49, 1'b0, 2'b00, 32'h0));
        foreach (ops[i]) begin
            e = model_access(ops[i]);
            access(ops[i], 1'b0, o);
            checks++;
            if (o !== e) $display("FAIL stats_seq[%0d] got %s expected %s", i, fmt(o), fmt(e));
            else passes++;
        end
`ifdef CACHE_STATS_EN
        checks++;
        if ({hit_count, miss_count} !== {m_hits, m_misses})
            $display("FAIL stats_counts got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     hit_count, miss_count, m_hits, m_misses);
        else passes++;
`endif
    endtask

    task automatic test_random();
        op_t op;
        result_t e, o;
        for (int i = 0; i < 250; i++) begin
            op.addr  = (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) op.addr = op.addr | 32'h8000_0000;
            op.wr    = 1'($urandom_range(0, 1));
            op.typ   = 2'($urandom_range(0, 3));
            op.wdata = $urandom;
            e = model_access(op);
            access(op, 1'($urandom_range(0, 1)), o);
            checks++;
            if (o !== e)
                $display("FAIL random[%0d] addr=%h wr=%b typ=%b got %s expected %s",
                         i, op.addr, op.wr, op.typ, fmt(o), fmt(e));
            else passes++;
        end
`ifdef CACHE_STATS_EN
        checks++;
        if ({hit_count, miss_count} !== {m_hits, m_misses})
            $display("FAIL random_counts got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     hit_count, miss_count, m_hits, m_misses);
        else passes++;
`endif
    endtask

    initial begin
        bus.Req_CPU   = 1'b0;
        bus.Wr_CPU    = 1'b0;
        bus.A_CPU     = '0;
        bus.Wdata_CPU = '0;
        bus.Ins_Type  = 2'b00;
        model_reset();
        test_reset();
        test_read_miss_hit();
        test_write_through();
        test_aliasing();
        test_ins_types();
        test_early_release();
        test_reset_mid_op();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
